seq_alu: RTL and testbench

Parametrised successor to the 4-bit registered ALU. Adds configurable width, a start/busy/done handshake, an accumulator path from the result register, and status flags (zero, signed overflow). Rotate-through-carry becomes a multi-cycle operation with a programmable count. It sits between the operand switches/registers and the display/readback logic of the lab datapath.

---
 rtl/seq_alu.sv | 134 +++++++++++++
 tb/tb_seq_alu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with an accumulator path, status flags and a multi-cycle
// rotate-through-carry driven by a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       modeSelect,
    input  logic             accSelect,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] RegOut,
    output logic             Carryout,
    output logic             Zero,
    output logic             Overflow
);

    typedef enum logic {IDLE, ROT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] rot_r, rot_r_nxt;
    logic             rot_c, rot_c_nxt;
    logic [WIDTH-1:0] reg_nxt;
    logic             cy_nxt, zero_nxt, ovf_nxt, done_nxt;
    logic [WIDTH-1:0] aeff;
    logic [WIDTH:0]   sum;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // One rotate step on the concatenation {carry, R}.
    function automatic logic [WIDTH:0] rot_step(input logic [WIDTH:0] cr);
        return {cr[WIDTH-1:0], cr[WIDTH]};
    endfunction

    assign aeff = accSelect ? RegOut : A;
    assign sum  = {1'b0, aeff} + {1'b0, B} + {{WIDTH{1'b0}}, C};
    assign busy = (state == ROT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rot_r_nxt = rot_r;
        rot_c_nxt = rot_c;
        reg_nxt   = RegOut;
        cy_nxt    = Carryout;
        ovf_nxt   = Overflow;
        done_nxt  = 1'b0;
        zero_nxt  = Zero;
        case (state)
            IDLE: begin
                if (start) begin
                    if (modeSelect == 3'b101 && B != '0) begin
                        state_nxt = ROT;
                        cnt_nxt   = B;
                        rot_r_nxt = aeff;
                        rot_c_nxt = C;
                    end else begin
                        done_nxt = 1'b1;
                        cy_nxt   = 1'b0;
                        ovf_nxt  = 1'b0;
                        case (modeSelect)
                            3'b000: reg_nxt = ~aeff;
                            3'b001: begin
                                reg_nxt = sum[WIDTH-1:0];
                                cy_nxt  = sum[WIDTH];
                                ovf_nxt = add_ovf($signed(aeff), $signed(B),
                                                  $signed(sum[WIDTH-1:0]));
                            end
                            3'b010: reg_nxt = aeff & B;
                            3'b011: reg_nxt = aeff | B;
                            3'b100: reg_nxt = aeff ^ B;
                            3'b101: begin
                                reg_nxt = aeff;
                                cy_nxt  = C;
                            end
                            3'b110: reg_nxt = '0;
                            3'b111: reg_nxt = '1;
                        endcase
                    end
                end
            end
            ROT: begin
                {rot_c_nxt, rot_r_nxt} = rot_step({rot_c, rot_r});
                cnt_nxt = cnt - 1'b1;
                if (cnt == WIDTH'(1)) begin
                    state_nxt = IDLE;
                    reg_nxt   = rot_r_nxt;
                    cy_nxt    = rot_c_nxt;
                    ovf_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (done_nxt) zero_nxt = (reg_nxt == '0);
    end

    // Control and committed outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            RegOut   <= '0;
            Carryout <= 1'b0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            RegOut   <= reg_nxt;
            Carryout <= cy_nxt;
            Zero     <= zero_nxt;
            Overflow <= ovf_nxt;
            done     <= done_nxt;
        end
    end

    // Rotate working register; only meaningful while in ROT
    always_ff @(posedge clock) begin
        rot_r <= rot_r_nxt;
        rot_c <= rot_c_nxt;
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed table, handshake corner cases and
// randomized operations against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset, start, accSelect, C;
    logic [2:0]   modeSelect;
    logic [W-1:0] A, B;
    logic         busy, done, Carryout, Zero, Overflow;
    logic [W-1:0] RegOut;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] m_reg;

    seq_alu #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .modeSelect(modeSelect),
        .accSelect(accSelect), .A(A), .B(B), .C(C), .busy(busy), .done(done),
        .RegOut(RegOut), .Carryout(Carryout), .Zero(Zero), .Overflow(Overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   mode;
        logic         acc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] er;
        logic         ecy;
        logic         eov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: rotate-through-carry B times is a left rotation of the
    // (W+1)-bit value {C, Aeff} by B mod (W+1).
    function automatic void model(input logic [2:0] mode, input logic [W-1:0] aeff,
                                  input logic [W-1:0] b, input logic c,
                                  output logic [W-1:0] r, output logic cy, output logic ov);
        int s, sa, sb, k, v, full;
        full = (1 << (W + 1)) - 1;
        r = '0; cy = 1'b0; ov = 1'b0;
        case (mode)
            3'd0: r = ~aeff;
            3'd1: begin
                s  = int'(aeff) + int'(b) + int'(c);
                r  = W'(s);
                cy = (s >= (1 << W));
                sa = aeff[W-1] ? int'(aeff) - (1 << W) : int'(aeff);
                sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
                s  = sa + sb + int'(c);
                ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            3'd2: r = aeff & b;
            3'd3: r = aeff | b;
            3'd4: r = aeff ^ b;
            3'd5: begin
                k  = int'(b) % (W + 1);
                v  = (int'(c) << W) | int'(aeff);
                v  = ((v << k) | (v >> (W + 1 - k))) & full;
                r  = W'(v);
                cy = v[W];
            end
            3'd6: r = '0;
            default: r = '1;
        endcase
    endfunction

    task automatic do_op(input string name, input logic [2:0] mode, input logic acc,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] er, input logic ecy, input logic eov);
        logic [W-1:0] held;
        held = m_reg;
        @(negedge clock);
        start = 1'b1; modeSelect = mode; accSelect = acc; A = a; B = b; C = c;
        @(posedge clock); #1;
        start = 1'b0;
        if (mode == 3'b101 && b != '0) begin
            for (int i = 0; i < int'(b); i++) begin
                check({name, "_busy"}, busy, 1'b1);
                check({name, "_hold"}, RegOut, held);
                check({name, "_nodone"}, done, 1'b0);
                @(posedge clock); #1;
            end
        end
        check({name, "_busyoff"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b1);
        check({name, "_reg"}, RegOut, er);
        check({name, "_cy"}, Carryout, ecy);
        check({name, "_zero"}, Zero, (er == '0));
        check({name, "_ovf"}, Overflow, eov);
        @(posedge clock); #1;
        check({name, "_donedrop"}, done, 1'b0);
        check({name, "_regkeep"}, RegOut, er);
        m_reg = er;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t         tbl[12];
        logic [W-1:0] er, held;
        logic         ecy, eov;
        logic [2:0]   mode;
        logic         acc;
        logic [W-1:0] a, b;
        logic         c;
        int           done_cnt;

        tbl[0]  = '{3'b001, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[1]  = '{3'b001, 1'b0, 4'h5, 4'h5, 1'b0, 4'hA, 1'b0, 1'b1};
        tbl[2]  = '{3'b000, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{3'b101, 1'b0, 4'h1, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0};
        tbl[4]  = '{3'b101, 1'b0, 4'hA, 4'h0, 1'b1, 4'hA, 1'b1, 1'b0};
        tbl[5]  = '{3'b110, 1'b0, 4'h7, 4'h3, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[6]  = '{3'b111, 1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0};
        tbl[7]  = '{3'b010, 1'b0, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0};
        tbl[8]  = '{3'b011, 1'b0, 4'hC, 4'hA, 1'b0, 4'hE, 1'b0, 1'b0};
        tbl[9]  = '{3'b100, 1'b0, 4'hC, 4'hA, 1'b0, 4'h6, 1'b0, 1'b0};
        tbl[10] = '{3'b101, 1'b0, 4'h8, 4'h5, 1'b0, 4'h8, 1'b0, 1'b0};
        tbl[11] = '{3'b001, 1'b1, 4'h0, 4'h7, 1'b1, 4'h0, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; modeSelect = '0; accSelect = 1'b0;
        A = '0; B = '0; C = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_reg", RegOut, 4'h0);
        check("rst_cy", Carryout, 1'b0);
        check("rst_zero", Zero, 1'b1);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        m_reg = '0;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            do_op($sformatf("vec%0d", i), tbl[i].mode, tbl[i].acc, tbl[i].a, tbl[i].b,
                  tbl[i].c, tbl[i].er, tbl[i].ecy, tbl[i].eov);

        // start pulse during a rotate must be dropped, not queued
        held = m_reg;
        @(negedge clock);
        start = 1'b1; modeSelect = 3'b101; accSelect = 1'b0; A = 4'h1; B = 4'h3; C = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("ign_busy1", busy, 1'b1);
        @(negedge clock);
        start = 1'b1; modeSelect = 3'b111;
        @(posedge clock); #1;
        start = 1'b0;
        check("ign_busy2", busy, 1'b1);
        check("ign_hold2", RegOut, held);
        @(posedge clock); #1;
        check("ign_busy3", busy, 1'b1);
        check("ign_hold3", RegOut, held);
        @(posedge clock); #1;
        check("ign_busyoff", busy, 1'b0);
        check("ign_done", done, 1'b1);
        check("ign_reg", RegOut, 4'hC);
        check("ign_cy", Carryout, 1'b0);
        @(posedge clock); #1;
        check("ign_noqueue_done", done, 1'b0);
        check("ign_noqueue_reg", RegOut, 4'hC);
        m_reg = 4'hC;

        // accumulate with start held for two cycles
        do_op("acc_seed", 3'b011, 1'b0, 4'h3, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0);
        @(negedge clock);
        start = 1'b1; modeSelect = 3'b001; accSelect = 1'b1; B = 4'h1; C = 1'b0;
        @(posedge clock); #1;
        check("acc1_reg", RegOut, 4'h4);
        check("acc1_done", done, 1'b1);
        @(posedge clock); #1;
        start = 1'b0; accSelect = 1'b0;
        check("acc2_reg", RegOut, 4'h5);
        check("acc2_done", done, 1'b1);
        @(posedge clock); #1;
        check("acc_donedrop", done, 1'b0);
        check("acc_keep", RegOut, 4'h5);
        m_reg = 4'h5;

        // reset in the middle of a rotate aborts with no commit
        @(negedge clock);
        start = 1'b1; modeSelect = 3'b101; accSelect = 1'b0; A = 4'h6; B = 4'h5; C = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        check("rr_busy1", busy, 1'b1);
        @(posedge clock); #1;
        check("rr_busy2", busy, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rr_reg", RegOut, 4'h0);
        check("rr_cy", Carryout, 1'b0);
        check("rr_zero", Zero, 1'b1);
        check("rr_busy", busy, 1'b0);
        check("rr_done", done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        check("rr_no_late_done", done_cnt, 0);
        m_reg = '0;
        do_op("post_reset", 3'b111, 1'b0, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0);

        // randomized operations against the reference model
        for (int n = 0; n < 150; n++) begin
            mode = 3'($urandom_range(0, 7));
            acc  = 1'($urandom_range(0, 1));
            a    = W'($urandom);
            b    = W'($urandom);
            c    = 1'($urandom_range(0, 1));
            model(mode, acc ? m_reg : a, b, c, er, ecy, eov);
            do_op($sformatf("rnd%0d_m%0d", n, mode), mode, acc, a, b, c, er, ecy, eov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
